// File: rtl/int_issue_sequencer.sv
// rtl/int_issue_sequencer.sv - integer op issue sequencer driving a combinational ALU from an 8x32 register file
//
// Purpose: accepts one integer op at a time, reads operands from the internal
// register file, drives registered operands/function to the ALU, waits a fixed
// settle latency, captures the result and writes it back.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_op/rd/rs1/rs2/use_c    request fields
//   alu_a/alu_b/alu_ci/alu_f   registered ALU inputs
//   alu_s/alu_co               ALU result and carry-out
//   resp_valid/data/err        one-cycle completion pulse with result/error
//   cflag                      carry flag
//   dbg_addr/dbg_data          combinational register-file read port
module int_issue_sequencer #(
    parameter int unsigned ALU_LAT    = 1,
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [2:0]  req_rd,
    input  logic [2:0]  req_rs1,
    input  logic [2:0]  req_rs2,
    input  logic        req_use_c,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_ci,
    output logic [4:0]  alu_f,
    input  logic [31:0] alu_s,
    input  logic        alu_co,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        cflag,
    input  logic [2:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [4:0]  OP_NOOP = 5'd0;
    localparam logic [4:0]  OP_ADD  = 5'd1;
    localparam logic [4:0]  OP_SUB  = 5'd2;
    localparam logic [4:0]  OP_MUL  = 5'd3;
    localparam logic [4:0]  OP_DIV  = 5'd4;
    localparam logic [4:0]  OP_MOD  = 5'd5;
    localparam logic [4:0]  OP_INC  = 5'd18;
    localparam logic [4:0]  OP_DEC  = 5'd19;
    localparam logic [4:0]  OP_CFL  = 5'd20;
    localparam logic [4:0]  OP_MAX  = 5'd22;

    localparam logic [15:0] ALU_CNT    = 16'(ALU_LAT - 1);
    localparam logic [15:0] MULDIV_CNT = 16'(MULDIV_LAT - 1);

    state_t      state_q, state_d;
    logic [31:0] rf_q [8];
    logic [31:0] rf_d [8];
    logic        cflag_q, cflag_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic        alu_ci_q, alu_ci_d;
    logic [4:0]  alu_f_q, alu_f_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  rd_q, rd_d;
    logic [4:0]  op_q, op_d;

    logic        req_incdec;
    logic        req_muldiv;
    logic        req_div0;
    logic [4:0]  req_f;
    logic        cflag_upd;

    always_comb begin
        req_incdec = (req_op == OP_INC) || (req_op == OP_DEC);
        req_muldiv = (req_op == OP_MUL) || (req_op == OP_DIV) || (req_op == OP_MOD);
        req_div0   = ((req_op == OP_DIV) || (req_op == OP_MOD)) && (rf_q[req_rs2] == 32'd0);
        // INC/DEC reuse the ADD/SUB datapath with an implicit operand of 1
        if (req_op == OP_INC) begin
            req_f = OP_ADD;
        end else if (req_op == OP_DEC) begin
            req_f = OP_SUB;
        end else begin
            req_f = req_op;
        end
        // Only true ADD/SUB (not INC/DEC) and op 20 produce a carry worth keeping
        cflag_upd = (((alu_f_q == OP_ADD) || (alu_f_q == OP_SUB))
                     && (op_q != OP_INC) && (op_q != OP_DEC))
                    || (op_q == OP_CFL);
    end

    always_comb begin
        state_d      = state_q;
        rf_d         = rf_q;
        cflag_d      = cflag_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ci_d     = alu_ci_q;
        alu_f_d      = alu_f_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        op_d         = op_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rd_d = req_rd;
                    op_d = req_op;
                    if (req_op == OP_NOOP) begin
                        state_d      = WB;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_data_d  = 32'd0;
                    end else if ((req_op > OP_MAX) || req_div0) begin
                        state_d      = WB;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = 32'd0;
                    end else begin
                        state_d  = EXEC;
                        alu_a_d  = rf_q[req_rs1];
                        alu_b_d  = req_incdec ? 32'd1 : rf_q[req_rs2];
                        alu_f_d  = req_f;
                        alu_ci_d = ((req_f == OP_ADD) || (req_f == OP_SUB))
                                   && req_use_c && !req_incdec && cflag_q;
                        cnt_d    = req_muldiv ? MULDIV_CNT : ALU_CNT;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 16'd0) begin
                    state_d      = WB;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = alu_s;
                    if (cflag_upd) begin
                        cflag_d = alu_co;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            WB: begin
                state_d = IDLE;
                alu_f_d = 5'd0;
                if (!resp_err_q && (op_q != OP_NOOP)) begin
                    rf_d[rd_q] = resp_data_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 32'd0;
            end
            cflag_q      <= 1'b0;
            alu_a_q      <= 32'd0;
            alu_b_q      <= 32'd0;
            alu_ci_q     <= 1'b0;
            alu_f_q      <= 5'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_err_q   <= 1'b0;
            cnt_q        <= 16'd0;
            rd_q         <= 3'd0;
            op_q         <= 5'd0;
        end else begin
            state_q      <= state_d;
            rf_q         <= rf_d;
            cflag_q      <= cflag_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ci_q     <= alu_ci_d;
            alu_f_q      <= alu_f_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            op_q         <= op_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ci     = alu_ci_q;
    assign alu_f      = alu_f_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign cflag      = cflag_q;
    assign dbg_data   = rf_q[dbg_addr];

endmodule

// File: tb/tb_int_issue_sequencer.sv
// tb/tb_int_issue_sequencer.sv - self-checking bench for int_issue_sequencer
`timescale 1ns/1ps
module tb_int_issue_sequencer;

    localparam int ALU_LAT    = 1;
    localparam int MULDIV_LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [2:0]  req_rd, req_rs1, req_rs2;
    logic        req_use_c;
    logic [31:0] alu_a, alu_b;
    logic        alu_ci;
    logic [4:0]  alu_f;
    logic [31:0] alu_s;
    logic        alu_co;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        cflag;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] m_rf [8];
    logic        m_c;
    logic [31:0] ext_val = 32'd0;
    logic [31:0] g;

    always #5 clk = ~clk;

    int_issue_sequencer #(.ALU_LAT(ALU_LAT), .MULDIV_LAT(MULDIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_use_c(req_use_c),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci), .alu_f(alu_f),
        .alu_s(alu_s), .alu_co(alu_co),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .cflag(cflag), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Stand-in combinational ALU: {co, s}. Function 21 returns a bench-chosen
    // value so registers can be preloaded; unknown functions return a^b, co=1.
    function automatic logic [32:0] alu_model(input logic [4:0] f, input logic [31:0] a,
                                              input logic [31:0] b, input logic ci,
                                              input logic [31:0] ev);
        case (f)
            5'd1:    return {1'b0, a} + {1'b0, b} + {32'd0, ci};
            5'd2:    return {1'b0, a} - {1'b0, b} - {32'd0, ci};
            5'd3:    return {1'b0, a * b};
            5'd4:    return (b == 0) ? 33'd0 : {1'b0, a / b};
            5'd5:    return (b == 0) ? 33'd0 : {1'b0, a % b};
            5'd20:   return {a[31], a[30:0], 1'b0};
            5'd21:   return {1'b0, ev};
            default: return {1'b1, a ^ b};
        endcase
    endfunction

    assign {alu_co, alu_s} = alu_model(alu_f, alu_a, alu_b, alu_ci, ext_val);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic dbg_check();
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #0.4;
            chk("dbg_rf", dbg_data, m_rf[i]);
        end
    endtask

    // Issues one request and checks it end to end against the sequencer model.
    task automatic do_op(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic uc, output logic [31:0] got);
        logic        is_alu, err, upd, ci, co;
        logic [4:0]  f;
        logic [31:0] a, b, res;
        logic [32:0] r;
        int          lat, edges;
        is_alu = 1'b0; err = 1'b0; upd = 1'b0; ci = 1'b0; co = 1'b0;
        f = 5'd0; a = 32'd0; b = 32'd0; res = 32'd0;
        if (op == 5'd0) begin
            err = 1'b0;
        end else if (op > 5'd22 || ((op == 5'd4 || op == 5'd5) && m_rf[rs2] == 32'd0)) begin
            err = 1'b1;
        end else begin
            is_alu = 1'b1;
            f   = (op == 5'd18) ? 5'd1 : (op == 5'd19) ? 5'd2 : op;
            a   = m_rf[rs1];
            b   = (op == 5'd18 || op == 5'd19) ? 32'd1 : m_rf[rs2];
            ci  = (op == 5'd1 || op == 5'd2) && uc && m_c;
            r   = alu_model(f, a, b, ci, ext_val);
            res = r[31:0];
            co  = r[32];
            upd = (op == 5'd1 || op == 5'd2 || op == 5'd20);
        end
        lat = is_alu ? (((op == 5'd3 || op == 5'd4 || op == 5'd5) ? MULDIV_LAT : ALU_LAT) + 1) : 1;

        @(negedge clk);
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_use_c = uc;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        edges = 1;
        // keep presenting junk while busy; it must be ignored
        req_op = 5'($urandom); req_rd = 3'($urandom); req_rs1 = 3'($urandom);
        req_rs2 = 3'($urandom); req_use_c = 1'($urandom);
        if (!is_alu) begin
            chk("f_zero_on_err", {27'd0, alu_f}, 32'd0);
        end
        while (resp_valid !== 1'b1 && edges < 40) begin
            chk("busy_ready", {31'd0, req_ready}, 32'd0);
            if (is_alu) begin
                chk("alu_f", {27'd0, alu_f}, {27'd0, f});
                chk("alu_a", alu_a, a);
                chk("alu_b", alu_b, b);
                chk("alu_ci", {31'd0, alu_ci}, {31'd0, ci});
            end
            @(posedge clk);
            #1;
            edges++;
        end
        chk("latency", 32'(edges), 32'(lat));
        chk("wb_ready", {31'd0, req_ready}, 32'd0);
        chk("resp_err", {31'd0, resp_err}, {31'd0, err});
        chk("resp_data", resp_data, res);
        got = resp_data;
        req_valid = 1'b0;
        if (upd) m_c = co;
        if (is_alu) m_rf[rd] = res;
        @(posedge clk);
        #1;
        chk("pulse_end", {31'd0, resp_valid}, 32'd0);
        chk("ready_back", {31'd0, req_ready}, 32'd1);
        chk("f_cleared", {27'd0, alu_f}, 32'd0);
        chk("cflag", {31'd0, cflag}, {31'd0, m_c});
        dbg_check();
    endtask

    task automatic ld(input logic [2:0] rd, input logic [31:0] v);
        logic [31:0] t;
        ext_val = v;
        do_op(5'd21, rd, 3'd0, 3'd0, 1'b0, t);
    endtask

    initial begin
        int pick;
        logic [4:0] op;
        for (int i = 0; i < 8; i++) m_rf[i] = 32'd0;
        m_c = 1'b0;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 5'd0; req_rd = 3'd0;
        req_rs1 = 3'd0; req_rs2 = 3'd0; req_use_c = 1'b0; dbg_addr = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_alu_f", {27'd0, alu_f}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_cflag", {31'd0, cflag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a MUL: no writeback, no response.
        ld(3'd1, 32'd5);
        ld(3'd2, 32'd6);
        @(negedge clk);
        req_op = 5'd3; req_rd = 3'd3; req_rs1 = 3'd1; req_rs2 = 3'd2; req_use_c = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("mul_issued", {27'd0, alu_f}, 32'd3);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) m_rf[i] = 32'd0;
        m_c = 1'b0;
        chk("arst_ready", {31'd0, req_ready}, 32'd1);
        chk("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("arst_alu_f", {27'd0, alu_f}, 32'd0);
        chk("arst_alu_a", alu_a, 32'd0);
        chk("arst_alu_b", alu_b, 32'd0);
        chk("arst_alu_ci", {31'd0, alu_ci}, 32'd0);
        chk("arst_resp_data", resp_data, 32'd0);
        dbg_check();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
            chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        end
        dbg_addr = 3'd3;
        #0.4;
        chk("mul_rd_untouched", dbg_data, 32'd0);

        // Directed cases
        ld(3'd1, 32'hFFFF_FFFF);
        ld(3'd2, 32'd1);
        do_op(5'd1, 3'd3, 3'd1, 3'd2, 1'b0, g);
        chk("add_wrap", g, 32'd0);
        chk("add_carry", {31'd0, cflag}, 32'd1);
        do_op(5'd1, 3'd3, 3'd1, 3'd2, 1'b1, g);
        chk("add_with_ci", g, 32'd1);
        ld(3'd4, 32'd100);
        ld(3'd5, 32'd7);
        do_op(5'd4, 3'd6, 3'd4, 3'd5, 1'b0, g);
        chk("div", g, 32'd14);
        do_op(5'd5, 3'd6, 3'd4, 3'd5, 1'b0, g);
        chk("mod", g, 32'd2);
        ld(3'd5, 32'd0);
        do_op(5'd4, 3'd6, 3'd4, 3'd5, 1'b0, g);
        chk("div0_data", g, 32'd0);
        dbg_addr = 3'd6;
        #0.4;
        chk("div0_rd_kept", dbg_data, 32'd2);
        do_op(5'd25, 3'd6, 3'd4, 3'd4, 1'b0, g);
        ld(3'd1, 32'd7);
        do_op(5'd18, 3'd1, 3'd1, 3'd0, 1'b1, g);
        chk("inc", g, 32'd8);
        do_op(5'd19, 3'd7, 3'd0, 3'd0, 1'b0, g);
        chk("dec_wrap", g, 32'hFFFF_FFFF);

        // Randomized ops against the model
        for (int n = 0; n < 150; n++) begin
            pick = int'($urandom_range(0, 19));
            case (pick)
                0, 1, 2, 3, 4, 5: op = 5'd21;
                6, 7:  op = 5'd1;
                8:     op = 5'd2;
                9:     op = 5'd3;
                10:    op = 5'd4;
                11:    op = 5'd5;
                12:    op = 5'd18;
                13:    op = 5'd19;
                14:    op = 5'd20;
                15:    op = 5'd0;
                16:    op = 5'($urandom_range(23, 31));
                17:    op = 5'($urandom_range(6, 17));
                18:    op = 5'd22;
                default: op = 5'($urandom_range(1, 2));
            endcase
            ext_val = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            do_op(op, 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/int_issue_sequencer.md
Name: int_issue_sequencer

Overview:
Initiator side of the integer ALU interface: accepts one integer op request at a time and reads operands from an internal 8x32 register file. Drives the ALU's a/b/ci/f inputs from registers, waits a fixed settle latency, captures s/co and writes the result back. Sits between the decode front-end and the combinational ALU inside the integer unit; never relies on the ALU's held-output behaviour.

Parameters:
ALU_LAT, 1, cycles alu_* held stable before sampling alu_s for non-mul/div ops (>=1)
MULDIV_LAT, 4, cycles held before sampling for MUL(3)/DIV(4)/MOD(5) (>=1)

Ports:
clk  in  1  single clock; one clock; reset is asynchronous and active-low
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present; fields held stable until accepted
req_ready  out  1  high only in IDLE
req_op  in  5  ALU function code 0..22
req_rd  in  3  destination register
req_rs1  in  3  source register A
req_rs2  in  3  source register B
req_use_c  in  1  1: ADD/SUB take ci from carry flag; 0: ci=0
alu_a  out  32  ALU operand a (registered)
alu_b  out  32  ALU operand b (registered)
alu_ci  out  1  ALU carry-in (registered)
alu_f  out  5  ALU function (registered)
alu_s  in  32  ALU result
alu_co  in  1  ALU carry-out
resp_valid  out  1  one-cycle completion pulse, no backpressure
resp_data  out  32  result (0 when resp_err)
resp_err  out  1  illegal op or divide-by-zero
cflag  out  1  carry flag
dbg_addr  in  3  debug register select
dbg_data  out  32  combinational read of rf[dbg_addr]

Behaviour:
- Reset (async, any state): state=IDLE, all rf entries=0, cflag=0, alu_f=0, alu_a=alu_b=0, alu_ci=0, resp_valid=0, resp_data=0, resp_err=0, counter=0. In-flight op dropped: no writeback, no resp.
- States: IDLE, EXEC, WB.
- IDLE: req_ready=1. Accept edge E0 when req_valid=1: latch rd, op; classify:
  - op 0 (NOOP) -> WB, err=0, no write.
  - op>22 -> WB, err=1, no write.
  - op 4/5 with rf[rs2]==0 -> WB, err=1, no write.
  - otherwise load alu_a=rf[rs1], alu_b=rf[rs2]. alu_f=op, except op 18 -> f=1 (ADD), b=1; op 19 -> f=2 (SUB), b=1. alu_ci=cflag if (f in {1,2} and req_use_c and op not 18/19) else 0. Counter = lat-1 (MULDIV_LAT for 3/4/5, else ALU_LAT). Go to EXEC.
- EXEC: alu_* held constant. Each edge: if counter==0, capture result=alu_s and go to WB. Else decrement.
- cflag is updated at the capture edge from alu_co for f=1/2 (not 18/19) and for op 20. Otherwise unchanged.
- WB (one cycle): resp_valid=1, resp_data/resp_err valid. At the WB->IDLE edge, rf[rd]=result when err=0 and op!=0.
- Latency, accept to resp_valid rise: L+1 edges for ALU ops, 1 edge for NOOP/error. Issue interval: L+2 cycles for ALU ops.
- Writeback completes before the next IDLE read, so back-to-back dependent ops need no bypass.
- req_valid while busy is ignored (ready=0).
- alu_f returns to 0 on the WB->IDLE edge. alu_a/b keep their last values.
- All 32-bit arithmetic wraps mod 2^32; ALU results are taken as-is.
- dbg_data: pure combinational read; shows the new value from the cycle after the write edge.

Test Plan:
- Preload r1=0xFFFFFFFF, r2=1, ADD(1) rd=r3, use_c=0 -> alu_f=1, ci=0; resp_valid 2 edges after accept, resp_data=0 → r3=0. cflag = sampled alu_co; drive alu_co=1 from the bench model -> cflag=1.
- Next ADD r1+r2 with use_c=1, cflag=1 -> alu_ci=1 during EXEC; alu_* stable for exactly ALU_LAT cycles.
- r4=100, r5=7, DIV(4) rd=r6 -> alu_* held 4 cycles; resp_valid 5 edges after accept; r6=14. Then MOD -> 2.
- DIV with r5=0, and op=25 -> resp_valid 1 edge after accept, resp_err=1, resp_data=0, rd unchanged, alu_f stays 0.
- INC(18) on r1=0x7 -> alu_f=1, alu_b=1, ci=0; r-dest=8. DEC(19) on 0 -> 0xFFFFFFFF.
- Assert rst_n=0 mid-EXEC of MUL -> immediate reset values, no resp_valid, rd still 0, req_ready=1 after release.
